// File: rtl/t_vga_v1_track_pkg.sv
// ---------------------------------------------------------------------------
// t_vga_v1_track_pkg
// Shared constants for the tracking-result FIFO and its Avalon-MM CSR block:
// register word addresses, STATUS/CTRL bit positions, reset values and the
// saturating drop-counter helper.
// ---------------------------------------------------------------------------
package t_vga_v1_track_pkg;

  // Avalon word addresses of the four CSR registers
  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_THRESH = 2'd3
  } csr_addr_e;

  // STATUS register bit positions (count occupies [AW:0])
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;
  localparam int STAT_UDF_BIT   = 11;
  localparam int STAT_DROP_LSB  = 16;

  // CONTROL register bit positions
  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  // Threshold after reset, and width of the lost-word counter
  localparam int THRESH_RST = 1;
  localparam int DROP_CNT_W = 8;

  // Lost-word counter sticks at all-ones instead of wrapping back to zero
  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/t_vga_v1_track_fifo_csr_mem.sv
// ---------------------------------------------------------------------------
// t_vga_v1_trk_fifo_mem
// Synchronous FIFO storage for the tracking-result words: storage array,
// read/write pointers, occupancy count, full/empty flags and flush.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   i_flush    in   empty the FIFO next cycle; discards same-cycle push/pop
//   i_push     in   push request (entry on i_wdata)
//   i_pop      in   pop request
//   i_wdata    in   entry to store
//   o_head     out  entry at the read pointer
//   o_count    out  occupancy, 0..DEPTH
//   o_empty    out  count == 0
//   o_full     out  count == DEPTH
//   o_push_ok  out  the push request is accepted this cycle
// ---------------------------------------------------------------------------
module t_vga_v1_trk_fifo_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_head,
  output logic [AW:0]   o_count,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_push_ok
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is also being popped; flush overrides both.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  assign o_push_ok = w_do_push;
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  // Pointers wrap naturally at DEPTH because they are exactly AW bits wide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset so it can map onto distributed/block RAM
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/t_vga_v1_track_fifo_csr.sv
// ---------------------------------------------------------------------------
// t_vga_v1_track_fifo_csr
// Buffers tracking-result words from the VGA object tracker and exposes them
// to the Nios II as an Avalon-MM slave (DATA pop-on-read, STATUS, CONTROL,
// THRESH) with a level watermark/overflow interrupt.
//
// Optional feature macro: TRACK_FIFO_FRAMETAG_EN
//   When defined, a 16-bit frame counter advances on in_sof and each entry
//   is tagged with it; DATA reads return the tag in [31:16].
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   pipeline result-word strobe
//   in_data    in   pipeline result word
//   in_sof     in   start-of-frame pulse (frame-tag build only)
//   address    in   Avalon word address
//   read       in   Avalon read strobe
//   write      in   Avalon write strobe
//   writedata  in   Avalon write data
//   readdata   out  registered read data, 1-cycle latency
//   irq        out  level interrupt to the Nios
// ---------------------------------------------------------------------------
module t_vga_v1_track_fifo_csr
  import t_vga_v1_track_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

`ifdef TRACK_FIFO_FRAMETAG_EN
  localparam int TAG_W   = 16;
  localparam int ENTRY_W = TAG_W + DATA_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  logic                  w_rd_data;
  logic                  w_wr_ctrl;
  logic                  w_wr_thresh;
  logic                  w_flush;
  logic                  w_clear;
  logic                  w_underflow_evt;
  logic                  w_drop_evt;
  logic                  w_push_ok;
  logic [ENTRY_W-1:0]    w_entry;
  logic [ENTRY_W-1:0]    w_head;
  logic [AW:0]           w_count;
  logic                  w_empty;
  logic                  w_full;
  logic [AW:0]           w_thresh_wr;
  logic [DROP_CNT_W-1:0] w_drop_base;
  logic [31:0]           w_data_word;
  logic [31:0]           w_rd_mux;
  logic                  w_unused_bits;

  logic                  r_overflow;
  logic                  r_underflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  r_irq_en;
  logic [AW:0]           r_thresh;
  logic                  r_irq;
  logic [31:0]           r_readdata;

  // Only some writedata bits are decoded; in_sof is only used with frame tags
  assign w_unused_bits = ^{writedata, in_sof};

  assign w_rd_data   = read  && (address == ADDR_DATA);
  assign w_wr_ctrl   = write && (address == ADDR_CTRL);
  assign w_wr_thresh = write && (address == ADDR_THRESH);
  assign w_flush     = w_wr_ctrl && writedata[CTRL_FLUSH_BIT];
  assign w_clear     = w_wr_ctrl && writedata[CTRL_CLEAR_BIT];

  // A DATA read on an empty FIFO is an underflow; a refused push that was
  // not swallowed by a flush is a lost word.
  assign w_underflow_evt = w_rd_data && w_empty;
  assign w_drop_evt      = in_valid && !w_push_ok && !w_flush;

  t_vga_v1_trk_fifo_mem #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (w_flush),
    .i_push    (in_valid),
    .i_pop     (w_rd_data),
    .i_wdata   (w_entry),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_push_ok (w_push_ok)
  );

`ifdef TRACK_FIFO_FRAMETAG_EN
  logic [TAG_W-1:0] r_frame_cnt;
  logic [TAG_W-1:0] w_tag;

  // A word arriving together with in_sof belongs to the new frame
  assign w_tag = in_sof ? r_frame_cnt + TAG_W'(1) : r_frame_cnt;

  // Frame counter survives flush; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_frame_cnt <= '0;
    else       r_frame_cnt <= w_tag;
  end

  assign w_entry     = {w_tag, in_data};
  assign w_data_word = {w_head[ENTRY_W-1 -: TAG_W], 16'(w_head[DATA_W-1:0])};
`else
  assign w_entry     = in_data;
  assign w_data_word = 32'(w_head);
`endif

  // Threshold of 0 would hold irq permanently; it is coerced to 1
  assign w_thresh_wr = writedata[AW:0];

  // Clearing and a new drop in the same cycle leave a count of one
  assign w_drop_base = w_clear ? '0 : r_drop_cnt;

  // Read mux follows the address every cycle, independent of the read strobe
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: begin
        if (!w_empty) w_rd_mux = w_data_word;
      end
      ADDR_STATUS: begin
        w_rd_mux[AW:0]                          = w_count;
        w_rd_mux[STAT_EMPTY_BIT]                = w_empty;
        w_rd_mux[STAT_FULL_BIT]                 = w_full;
        w_rd_mux[STAT_OVF_BIT]                  = r_overflow;
        w_rd_mux[STAT_UDF_BIT]                  = r_underflow;
        w_rd_mux[STAT_DROP_LSB +: DROP_CNT_W]   = r_drop_cnt;
      end
      ADDR_CTRL: begin
        w_rd_mux[CTRL_IRQEN_BIT] = r_irq_en;
      end
      ADDR_THRESH: begin
        w_rd_mux[AW:0] = r_thresh;
      end
      default: w_rd_mux = '0;
    endcase
  end

  // Sticky error flags: a new event in the clear cycle wins over the clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_clear) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
        r_drop_cnt  <= '0;
      end
      if (w_drop_evt) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= sat_inc_drop(w_drop_base);
      end
      if (w_underflow_evt) r_underflow <= 1'b1;
    end
  end

  // Software-written configuration: irq enable and watermark threshold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_thresh <= (AW+1)'(THRESH_RST);
    end else begin
      if (w_wr_ctrl) r_irq_en <= writedata[CTRL_IRQEN_BIT];
      if (w_wr_thresh) begin
        r_thresh <= (w_thresh_wr == '0) ? (AW+1)'(1) : w_thresh_wr;
      end
    end
  end

  // Registered outputs: irq lags its condition by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_irq      <= r_irq_en && ((w_count >= r_thresh) || r_overflow);
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
